// File: rtl/uart_tx_sched_pkg.sv
// Shared state type, frame constants and id-width helper for uart_tx_sched.
// Defining UART_TX_PARITY_EN adds the even-parity bit state.
package uart_pkg;

    localparam int unsigned UART_DATA_W    = 8;
    localparam int unsigned UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_TX_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    // Index width that stays at least one bit for a single requester.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_arb.sv
// Round-robin arbiter: first asserted request at or above ptr, wrapping to 0.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]           req,
    input  logic [id_width(NREQ)-1:0] ptr,
    input  logic                      en,
    output logic [NREQ-1:0]           grant,
    output logic [id_width(NREQ)-1:0] grant_idx
);

    localparam int unsigned IdW = id_width(NREQ);

    logic        hi_hit;
    logic        lo_hit;
    int unsigned hi_idx;
    int unsigned lo_idx;
    int unsigned sel;

    // Lowest request at/above ptr wins; otherwise the lowest request overall.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = 0;
        lo_idx = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req[i] && !lo_hit) begin
                lo_hit = 1'b1;
                lo_idx = i;
            end
            if (req[i] && !hi_hit && (i >= 32'(ptr))) begin
                hi_hit = 1'b1;
                hi_idx = i;
            end
        end
        sel = hi_hit ? hi_idx : lo_idx;
        grant = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant[i] = en && lo_hit && (i == sel);
        end
        grant_idx = IdW'(sel);
    end

endmodule

// File: rtl/uart_tx_sched_baud.sv
// Fractional-accumulator baud tick generator; disabling it re-seeds the phase.
module baud_tick_gen #(
    parameter int unsigned ClkFrequency = 50000000,
    parameter int unsigned Baud         = 115200,
    parameter int unsigned Oversampling = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick_c
);

    localparam int unsigned     AccW  = 24;
    localparam logic [63:0]     Inc64 = (((64'(Baud) * 64'(Oversampling)) << AccW)
                                         + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
    localparam logic [AccW-1:0] Inc   = AccW'(Inc64);

    logic [AccW-1:0] acc;
    logic [AccW:0]   sum;

    assign sum    = {1'b0, acc} + {1'b0, Inc};
    assign tick_c = enable & sum[AccW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (enable) begin
            acc <= sum[AccW-1:0];
        end else begin
            acc <= '0;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Multi-requester UART transmitter: round-robin byte accept, 8N1 serialiser.
// Defining UART_TX_PARITY_EN switches the frame to 8E1.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned ClkFrequency = 50000000,
    parameter int unsigned Baud         = 115200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [8*NREQ-1:0]         req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      tx,
    output logic                      busy,
    output logic [id_width(NREQ)-1:0] grant_id,
    output logic                      frame_done
);

    localparam int unsigned IdW  = id_width(NREQ);
    localparam int unsigned CntW = $clog2(UART_DATA_W);

    tx_state_e              state;
    logic [UART_DATA_W-1:0] shift;
    logic [UART_DATA_W-1:0] win_byte;
    logic [CntW-1:0]        bitcnt;
    logic [IdW-1:0]         ptr;
    logic [IdW-1:0]         ptr_next;
    logic [IdW-1:0]         win_idx;
    logic                   in_idle;
    logic                   tick;
`ifdef UART_TX_PARITY_EN
    logic                   parity;
`endif

    assign in_idle = (state == TX_IDLE);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .en        (in_idle),
        .grant     (req_ready),
        .grant_idx (win_idx)
    );

    baud_tick_gen #(
        .ClkFrequency (ClkFrequency),
        .Baud         (Baud),
        .Oversampling (1)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .enable (!in_idle),
        .tick_c (tick)
    );

    // Winner's byte and the pointer one past it.
    always_comb begin
        win_byte = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (32'(win_idx) == i) begin
                win_byte = req_data[UART_DATA_W*i +: UART_DATA_W];
            end
        end
        ptr_next = (win_idx == IdW'(NREQ - 1)) ? '0 : win_idx + IdW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= TX_IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            grant_id   <= '0;
            ptr        <= '0;
            shift      <= '0;
            bitcnt     <= '0;
`ifdef UART_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (|req_ready) begin
                        shift    <= win_byte;
                        grant_id <= win_idx;
                        ptr      <= ptr_next;
                        bitcnt   <= '0;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                        state    <= TX_START;
`ifdef UART_TX_PARITY_EN
                        parity   <= ^win_byte;
`endif
                    end
                end
                TX_START: begin
                    if (tick) begin
                        tx    <= shift[0];
                        state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        shift  <= shift >> 1;
                        bitcnt <= bitcnt + CntW'(1);
                        if (bitcnt == CntW'(UART_DATA_W - 1)) begin
                            bitcnt <= '0;
`ifdef UART_TX_PARITY_EN
                            tx     <= parity;
                            state  <= TX_PARITY;
`else
                            tx     <= 1'b1;
                            state  <= TX_STOP;
`endif
                        end else begin
                            tx <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= TX_STOP;
                    end
                end
`endif
                // bitcnt is reused to count stop bits.
                TX_STOP: begin
                    if (tick) begin
                        if (bitcnt == CntW'(UART_STOP_BITS - 1)) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= TX_IDLE;
                        end else begin
                            bitcnt <= bitcnt + CntW'(1);
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (NREQ=2, 1 MHz clk, 100 kbaud).
// Follows UART_TX_PARITY_EN to expect 8E1 frames when it is defined.
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam int unsigned NREQ = 2;
    localparam int          TB   = 10;
`ifdef UART_TX_PARITY_EN
    localparam int          FBITS = 11;
`else
    localparam int          FBITS = 10;
`endif
    localparam int          FLEN = FBITS * TB;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        tx;
    logic        busy;
    logic [0:0]  grant_id;
    logic        frame_done;

    int tests = 0;
    int fails = 0;
    int model_ptr = 0;

    typedef struct {
        logic [1:0] valid;
        logic [1:0] exp_ptr0;
        logic [1:0] exp_ptr1;
    } vec_t;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NREQ         (NREQ),
        .ClkFrequency (1000000),
        .Baud         (100000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level of bit slot n of a frame carrying byte b.
    function automatic logic line_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[3'(slot - 1)];
`ifdef UART_TX_PARITY_EN
        if (slot == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Reference round-robin choice: first valid index from p upward, wrapping.
    function automatic int rr_pick(input logic [1:0] v, input int p);
        for (int j = 0; j < int'(NREQ); j++) begin
            if (v[1'((p + j) % int'(NREQ))]) return (p + j) % int'(NREQ);
        end
        return -1;
    endfunction

    // Called at an IDLE sample point where requester g is expected to win on the next edge.
    task automatic expect_frame(input logic [7:0] b, input int g,
                                input logic [1:0] mid_valid, input logic [15:0] mid_data);
        chk("ready_at_accept", 32'(req_ready), 32'(1 << g));
        for (int k = 0; k <= FLEN; k++) begin
            @(negedge clk);
            if (k == 3 * TB) begin
                req_valid = mid_valid;
                req_data  = mid_data;
            end
            #1;
            if (k == 0) chk("grant_id", 32'(grant_id), 32'(g));
            chk("tx", 32'(tx), 32'((k < FLEN) ? line_bit(b, k / TB) : 1'b1));
            chk("busy", 32'(busy), 32'(k < FLEN));
            chk("frame_done", 32'(frame_done), 32'(k == FLEN));
            if (k < FLEN) chk("ready_midframe", 32'(req_ready), 32'(0));
        end
        model_ptr = (g + 1) % int'(NREQ);
    endtask

    task automatic present(input logic [1:0] v, input logic [15:0] d);
        req_valid = v;
        req_data  = d;
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   g;
        logic [1:0]  m;
        logic [15:0] d;

        vecs[0] = '{2'b00, 2'b00, 2'b00};
        vecs[1] = '{2'b01, 2'b01, 2'b01};
        vecs[2] = '{2'b10, 2'b10, 2'b10};
        vecs[3] = '{2'b11, 2'b01, 2'b10};

        rst = 1'b1;
        req_valid = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));
        chk("rst_grant_id", 32'(grant_id), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // Readiness table with ptr=0; valid is withdrawn before every edge.
        for (int i = 0; i < 4; i++) begin
            present(vecs[i].valid, 16'h2211);
            chk("tbl_ready_p0", 32'(req_ready), 32'(vecs[i].exp_ptr0));
            req_valid = '0;
            @(negedge clk);
            #1;
            chk("withdrawn_tx", 32'(tx), 32'(1));
            chk("withdrawn_busy", 32'(busy), 32'(0));
        end

        // Single frame 0xA5 from requester 0.
        present(2'b01, 16'h00A5);
        expect_frame(8'hA5, 0, 2'b00, 16'h00A5);

        // Readiness table with ptr=1.
        for (int i = 0; i < 4; i++) begin
            present(vecs[i].valid, 16'h2211);
            chk("tbl_ready_p1", 32'(req_ready), 32'(vecs[i].exp_ptr1));
            req_valid = '0;
            @(negedge clk);
            #1;
        end

        // Both requesters continuously valid: grants alternate.
        present(2'b11, 16'h2211);
        for (int n = 0; n < 6; n++) begin
            g = rr_pick(2'b11, model_ptr);
            expect_frame((g == 1) ? 8'h22 : 8'h11, g, 2'b11, 16'h2211);
        end

        // Requester 1 raises valid during requester 0's data bits.
        present(2'b01, 16'h7E4C);
        g = rr_pick(2'b01, model_ptr);
        chk("mid_first_pick", 32'(g), 32'(0));
        expect_frame(8'h4C, g, 2'b11, 16'h7E4C);
        g = rr_pick(2'b11, model_ptr);
        expect_frame(8'h7E, g, 2'b00, 16'h0000);

        // Reset at data bit 4 aborts the frame immediately.
        present(2'b01, 16'h005A);
        chk("abort_ready", 32'(req_ready), 32'(1));
        @(negedge clk);
        req_valid = '0;
        repeat (5 * TB) @(negedge clk);
        #1;
        chk("abort_tx_before", 32'(tx), 32'(line_bit(8'h5A, 5)));
        chk("abort_busy_before", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        chk("abort_tx", 32'(tx), 32'(1));
        chk("abort_busy", 32'(busy), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        @(negedge clk);
        #1;
        chk("after_abort_tx", 32'(tx), 32'(1));
        present(2'b11, 16'hC33C);
        expect_frame(8'h3C, rr_pick(2'b11, model_ptr), 2'b00, 16'h0000);

        // Parity-sensitive bytes.
        present(2'b01, 16'h00A5);
        expect_frame(8'hA5, 0, 2'b00, 16'h0000);
        present(2'b01, 16'h0001);
        expect_frame(8'h01, 0, 2'b00, 16'h0000);

        // Randomized requests against the round-robin model.
        for (int n = 0; n < 40; n++) begin
            req_valid = '0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1;
            m = 2'($urandom_range(0, 3));
            d = 16'($urandom);
            present(m, d);
            g = rr_pick(m, model_ptr);
            if (g < 0) begin
                chk("rand_no_ready", 32'(req_ready), 32'(0));
                @(negedge clk);
                #1;
                chk("rand_idle_tx", 32'(tx), 32'(1));
            end else begin
                expect_frame(d[8*g +: 8], g, 2'($urandom_range(0, 3)), d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Multi-requester UART transmit scheduler. It arbitrates byte requests from NREQ clients round-robin and serialises the granted byte as an 8N1 frame, or 8E1 when parity is compiled in. It sequences an internal baud tick generator, enabling it only while a frame is on the line. It sits between on-chip producers (result streamer, debug/status reporter) and the single board UART TX pin.

## Interface
Parameters:
- NREQ, 2: number of requesters, legal 1..8.
- ClkFrequency, 50000000: clk frequency in Hz.
- Baud, 115200: line bit rate.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i has a byte pending.
- req_data  in  8*NREQ  byte i at [8*i+7:8*i].
- req_ready  out  NREQ  one-hot accept strobe; combinational.
- tx  out  1  serial line, registered; idle high.
- busy  out  1  high from the accept edge until return to IDLE.
- grant_id  out  max(1,$clog2(NREQ))  index of the last accepted requester; registered.
- frame_done  out  1  one-cycle pulse on the STOP-to-IDLE transition.

## Operation
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE:
  - Baud enable is low; tx=1.
  - If any req_valid bit is set, the round-robin winner g is the first valid index searched from ptr upward, wrapping.
  - req_ready = onehot(g) only while in IDLE; 0 in every other state.
- Handshake:
  - A transfer occurs at the edge where req_valid[g] & req_ready[g].
  - A requester holds valid and data stable until its ready is seen.
  - Deasserting valid before ready is legal: no transfer occurs and the winner is re-evaluated the next cycle.
- On transfer:
  - shift <= byte g; grant_id <= g; ptr <= (g+1) mod NREQ; bitcnt <= 0.
  - State moves to START, busy <= 1.
- START: tx=0, baud enable high. On tick, go to DATA.
- DATA:
  - tx = shift[0], sent LSB first.
  - On each tick: shift >>= 1, bitcnt++.
  - On the tick where bitcnt==7, go to PARITY (if compiled in) or STOP.
- STOP: tx=1. On tick, go to IDLE; frame_done pulses; busy <= 0; baud enable drops.
- Baud enable is low in IDLE, which re-seeds the tick accumulator. The first tick of every frame therefore lands a full bit period after START entry, with no phase carry-over between frames.
- Back-to-back frames have a minimum of 1 IDLE cycle between the STOP tick and the next accept. Requester fairness holds: a continuously-valid client waits at most NREQ-1 frames.
- NREQ=1: ptr is constant 0 and grant_id is 1 bit, always 0.
- Requests arriving mid-frame are ignored until IDLE; nothing is queued.

## Timing
- Reset values: tx=1, busy=0, frame_done=0, grant_id=0, ptr=0 (requester 0 has highest initial priority), state=IDLE, baud enable=0.
- Reset mid-frame aborts the frame. tx goes high asynchronously, with no partial stop bit. The pending byte is lost, and the requester is not re-signalled because its ready has already fired.
- Bit period: Tb ≈ ClkFrequency/Baud clk cycles, with the tick generator's fractional accumulator error (<2% over a frame).
- Accept edge to tx falling: 1 clk.
- Frame length:
  - 10 bit periods without parity, 11 with parity.
  - Exact clk count is set by tick positions.
- frame_done is asserted 1 clk after the STOP tick edge, together with busy falling.
- tick and the accept handshake are never active in the same state, so there are no simultaneous-event conflicts.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state is inserted after DATA.
  - tx = even parity (XOR of the 8 data bits, captured at accept) for one bit period.
  - Frame is 11 bits.
- Undefined: PARITY state, parity register and parity logic are absent; frame is 8N1.

## Structure
- Package uart_pkg:
  - typedef enum for the tx state.
  - UART_DATA_W=8 and UART_STOP_BITS=1 constants.
  - function for the grant_id width.
- Sub-module rr_arbiter (NREQ): inputs req, ptr and en; outputs a one-hot grant and its index.
- The existing baud tick generator is instantiated with Oversampling=1; its enable is driven by the FSM.

## Test plan
All scenarios use ClkFrequency=1000000, Baud=100000 (Tb ≈ 10 clk).
- Single frame:
  - Stimulus: req0 sends 0xA5.
  - Required: tx = 0,1,0,1,0,0,1,0,1,1 at ~10 clk each; req_ready[0] pulses once; frame_done pulses once; grant_id=0.
- Round robin:
  - Stimulus: req0 and req1 valid continuously with 0x11 and 0x22, NREQ=2.
  - Required: frames alternate 0x11, 0x22, 0x11, …; grant_id toggles; no starvation.
- Mid-frame request:
  - Stimulus: req1 raises valid during the req0 DATA phase.
  - Required: req_ready stays 0 until IDLE, then req1 is granted; ≥1 IDLE cycle between frames.
- Reset during DATA:
  - Stimulus: assert rst at bit 4.
  - Required: tx=1 and busy=0 immediately. After release, a new 0x3C frame starts with a full-length start bit (tick re-seeded).
- Valid withdrawn:
  - Stimulus: req0 valid for 0 cycles of ready overlap (dropped before the IDLE edge).
  - Required: no frame, and tx stays 1.
- Parity (UART_TX_PARITY_EN):
  - Stimulus: 0xA5, then 0x01.
  - Required: 0xA5 has parity bit 0 and 0x01 has parity bit 1; each frame is 11 Tb long.
